conv_scan_scheduler: RTL and testbench
======================================

# conv_scan_scheduler

Sequences the row router controller across a full convolution layer. Walks output coordinates (o_x fastest, then o_y) for a given input size, kernel size and stride. For each output pixel it enables the row router controller, waits for its completion flag, and presents the window to the PE array under a valid/ready handshake. It then clears the router controller and advances to the next pixel. Sits between the layer-configuration registers and `row_router_controller`.

## Interface
- ADDR_WIDTH, 8, width of coordinates and sizes (matches `row_router_controller`)
- CNT_WIDTH, 16, width of the window counter
- i_clk  in  1  clock, rising edge
- i_nrst  in  1  asynchronous active-low reset
- i_reg_clear  in  1  synchronous clear, returns block to IDLE
- i_start  in  1  layer start; sampled only in IDLE
- i_i_size  in  ADDR_WIDTH  input feature-map side length (square)
- i_k_size  in  ADDR_WIDTH  kernel side length
- i_stride  in  ADDR_WIDTH  stride
- o_o_x, o_o_y  out  ADDR_WIDTH  current output coordinate; drives router controller i_o_x/i_o_y
- o_i_size  out  ADDR_WIDTH  latched input size; drives router controller i_i_size
- o_rrc_en  out  1  router controller enable (its i_en)
- o_rrc_clear  out  1  router controller clear (its i_reg_clear)
- i_rrc_done  in  1  router controller completion (its o_rr_en)
- o_win_valid  out  1  window coordinates ready for PE array
- i_pe_ready  in  1  PE array accepts window
- o_win_count  out  CNT_WIDTH  windows accepted since start
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at layer end
- o_err  out  1  sticky configuration error, cleared on next accepted start

## Operation
- States: IDLE, LOAD, RUN, HOLD, ADV, DONE. State is registered. All outputs are decoded from registered state and registers; no input-to-output combinational path.
- IDLE: if i_start=1, go to LOAD and clear o_err.
- LOAD: latch i_i_size, i_k_size and i_stride into shadow registers. Set o_o_x=o_o_y=0, base_x=base_y=0 and o_win_count=0.
  - If k=0, stride=0 or k>i_size: set o_err=1 and go to DONE.
  - Otherwise go to RUN.
- RUN: o_rrc_en=1. Stay until i_rrc_done=1, then go to HOLD.
- HOLD: o_win_valid=1, and o_rrc_en stays 1 so the router outputs remain stable. On i_pe_ready=1, increment o_win_count and go to ADV.
- ADV: o_rrc_clear=1 for exactly one cycle and o_rrc_en=0. Coordinates update on exiting ADV:
  - Column step: if base_x+stride+k ≤ i_size, then o_o_x+=1 and base_x+=stride.
  - Row step: else if base_y+stride+k ≤ i_size, then o_o_x=0, base_x=0, o_o_y+=1 and base_y+=stride.
  - Last window: else go to DONE.
  - Otherwise (column or row step) go to RUN.
- DONE: o_done=1 for one cycle, then IDLE. Coordinates and o_win_count hold their final values until the next LOAD.
- Arithmetic: the base+stride+k comparisons are evaluated at ADDR_WIDTH+2 bits, so there is no wrap-around. No divider is used; the output size is implicit, equal to floor((i_size−k)/stride)+1 per axis.
- Ignored inputs:
  - i_start outside IDLE.
  - i_rrc_done outside RUN.
  - i_pe_ready outside HOLD.
  - Changes to i_i_size, i_k_size or i_stride after LOAD.
- i_reg_clear has priority over every transition. On the next edge it forces IDLE, with all outputs at their reset values and o_err cleared.

## Timing
- Reset values (async, i_nrst=0):
  - state=IDLE.
  - o_o_x, o_o_y, o_i_size and o_win_count are 0.
  - o_rrc_en, o_rrc_clear, o_win_valid, o_busy, o_done and o_err are 0.
- i_start high at edge n puts the block in LOAD in cycle n+1 and RUN in cycle n+2, with o_rrc_en high from n+2.
- Per-window minimum is 3 cycles (RUN, HOLD, ADV), achieved when i_rrc_done and i_pe_ready are both 1 on the first cycle of their states.
- o_win_valid rises the cycle after i_rrc_done is sampled high. It falls the cycle after i_pe_ready is sampled high.
- o_rrc_clear is always a single-cycle pulse. It is asserted in ADV and precedes the coordinate update seen in the next RUN.
- o_done is asserted in the cycle after the final ADV (or the cycle after LOAD on error). o_busy is low in that same cycle's successor.
- Reset mid-operation: outputs return to reset values immediately, asynchronously. A new i_start is required afterward.

## Test plan
- i_size=5, k=3, stride=1, with i_rrc_done and i_pe_ready tied 1: exactly 9 windows in the order (0,0),(1,0),(2,0),(0,1)…(2,2). o_win_count=9, and one o_done pulse 3·9+2 cycles after start.
- i_size=7, k=3, stride=2: 3×3 windows with max o_o_x=o_o_y=2. i_size=6, k=3, stride=2: 2×2 windows.
- Backpressure: i_pe_ready low for 4 cycles on window (1,0). o_win_valid, o_o_x=1 and o_rrc_en all hold steady, and o_rrc_clear stays 0 until accept.
- Config errors: each of k=0, stride=0, and k=6 with i_size=5 gives o_err=1, o_done pulse, zero windows and o_rrc_en never high. o_err clears on the next valid start.
- i_reg_clear asserted in HOLD, then separately i_nrst pulsed in RUN: next cycle IDLE with all outputs 0. i_start while busy has no effect.
- Edge case k=i_size=4, stride=3: exactly one window (0,0), then DONE.

Source files
------------

// File: rtl/conv_scan_scheduler.sv
// Layer-level scan scheduler: walks output pixels of a square convolution,
// driving row_router_controller per pixel and handing each window to the PE array.
module conv_scan_scheduler #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_reg_clear,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_k_size,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    output logic [ADDR_WIDTH-1:0] o_o_x,
    output logic [ADDR_WIDTH-1:0] o_o_y,
    output logic [ADDR_WIDTH-1:0] o_i_size,
    output logic                  o_rrc_en,
    output logic                  o_rrc_clear,
    input  logic                  i_rrc_done,
    output logic                  o_win_valid,
    input  logic                  i_pe_ready,
    output logic [CNT_WIDTH-1:0]  o_win_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    // Window handshake: a window transfers on a rising clock edge where
    // o_win_valid and i_pe_ready are both 1; o_win_valid never drops before that.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_HOLD = 3'd3,
        S_ADV  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int SW = ADDR_WIDTH + 2;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] ox_q;
    logic [ADDR_WIDTH-1:0] oy_q;
    logic [ADDR_WIDTH-1:0] size_q;
    logic [ADDR_WIDTH-1:0] k_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] base_x;
    logic [ADDR_WIDTH-1:0] base_y;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  err_q;
    logic                  cfg_bad;
    logic                  col_fit;
    logic                  row_fit;
    logic [SW-1:0]         col_sum;
    logic [SW-1:0]         row_sum;

    assign cfg_bad = (i_k_size == '0) || (i_stride == '0) || (i_k_size > i_i_size);

    // Widened sums so base+stride+k can never wrap before the compare.
    assign col_sum = SW'(base_x) + SW'(stride_q) + SW'(k_q);
    assign row_sum = SW'(base_y) + SW'(stride_q) + SW'(k_q);
    assign col_fit = (col_sum <= SW'(size_q));
    assign row_fit = (row_sum <= SW'(size_q));

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= S_IDLE;
        end else if (i_reg_clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_start) state_nxt = S_LOAD;
            S_LOAD: state_nxt = cfg_bad ? S_DONE : S_RUN;
            S_RUN:  if (i_rrc_done) state_nxt = S_HOLD;
            S_HOLD: if (i_pe_ready) state_nxt = S_ADV;
            S_ADV:  state_nxt = (col_fit || row_fit) ? S_RUN : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            ox_q     <= '0;
            oy_q     <= '0;
            size_q   <= '0;
            k_q      <= '0;
            stride_q <= '0;
            base_x   <= '0;
            base_y   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else if (i_reg_clear) begin
            ox_q     <= '0;
            oy_q     <= '0;
            size_q   <= '0;
            k_q      <= '0;
            stride_q <= '0;
            base_x   <= '0;
            base_y   <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (i_start) err_q <= 1'b0;
                S_LOAD: begin
                    size_q   <= i_i_size;
                    k_q      <= i_k_size;
                    stride_q <= i_stride;
                    ox_q     <= '0;
                    oy_q     <= '0;
                    base_x   <= '0;
                    base_y   <= '0;
                    count_q  <= '0;
                    if (cfg_bad) err_q <= 1'b1;
                end
                S_HOLD: if (i_pe_ready) count_q <= count_q + CNT_WIDTH'(1);
                S_ADV: begin
                    if (col_fit) begin
                        ox_q   <= ox_q + ADDR_WIDTH'(1);
                        base_x <= base_x + stride_q;
                    end else if (row_fit) begin
                        ox_q   <= '0;
                        base_x <= '0;
                        oy_q   <= oy_q + ADDR_WIDTH'(1);
                        base_y <= base_y + stride_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control outputs are pure decodes of the registered state.
    always_comb begin
        o_rrc_en    = 1'b0;
        o_rrc_clear = 1'b0;
        o_win_valid = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (state)
            S_IDLE: o_busy = 1'b0;
            S_RUN:  o_rrc_en = 1'b1;
            S_HOLD: begin
                o_rrc_en    = 1'b1;
                o_win_valid = 1'b1;
            end
            S_ADV:  o_rrc_clear = 1'b1;
            S_DONE: o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_o_x       = ox_q;
    assign o_o_y       = oy_q;
    assign o_i_size    = size_q;
    assign o_win_count = count_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_conv_scan_scheduler.sv
// Randomized bench for conv_scan_scheduler: window order and counts come from a
// loop-based model of the output grid, timing from the state sequence rules.
module tb_conv_scan_scheduler;

    localparam int AW     = 8;
    localparam int CW     = 16;
    localparam int BUDGET = 6000;

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic          i_reg_clear = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_i_size = '0;
    logic [AW-1:0] i_k_size = '0;
    logic [AW-1:0] i_stride = '0;
    logic [AW-1:0] o_o_x;
    logic [AW-1:0] o_o_y;
    logic [AW-1:0] o_i_size;
    logic          o_rrc_en;
    logic          o_rrc_clear;
    logic          i_rrc_done = 1'b0;
    logic          o_win_valid;
    logic          i_pe_ready = 1'b0;
    logic [CW-1:0] o_win_count;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    conv_scan_scheduler #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_reg_clear(i_reg_clear), .i_start(i_start),
        .i_i_size(i_i_size), .i_k_size(i_k_size), .i_stride(i_stride),
        .o_o_x(o_o_x), .o_o_y(o_o_y), .o_i_size(o_i_size),
        .o_rrc_en(o_rrc_en), .o_rrc_clear(o_rrc_clear), .i_rrc_done(i_rrc_done),
        .o_win_valid(o_win_valid), .i_pe_ready(i_pe_ready), .o_win_count(o_win_count),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_en"}, o_rrc_en, 0);
        check({tag, "_clr"}, o_rrc_clear, 0);
        check({tag, "_valid"}, o_win_valid, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_err"}, o_err, 0);
        check({tag, "_xy"}, {o_o_y, o_o_x}, 0);
        check({tag, "_isize"}, o_i_size, 0);
        check({tag, "_count"}, o_win_count, 0);
    endtask

    // Output grid: n = floor((i-k)/s)+1 per axis, row-major with x fastest.
    task automatic build_expect(input int isz, input int k, input int s,
                                output int nwin, output int n, output bit err);
        exp_q.delete();
        err = (k == 0) || (s == 0) || (k > isz);
        n = err ? 0 : (isz - k) / s + 1;
        nwin = n * n;
        for (int oy = 0; oy < n; oy++)
            for (int ox = 0; ox < n; ox++) begin
                logic [15:0] e;
                e = {8'(oy), 8'(ox)};
                exp_q.push_back(e);
            end
    endtask

    // mode 0: done/ready tied high; 1: random; 2: ready held low 4 cycles on window (1,0)
    task automatic run_layer(input int isz, input int k, input int s, input int mode);
        int nwin, n, c, done_c, stall, acc;
        bit err, prev_clr, en_seen, exp_rise, exp_fall;
        logic [15:0] e;
        build_expect(isz, k, s, nwin, n, err);
        @(negedge i_clk);
        i_i_size = 8'(isz);
        i_k_size = 8'(k);
        i_stride = 8'(s);
        i_reg_clear = 1'b0;
        i_rrc_done = 1'b1;
        i_pe_ready = 1'b1;
        i_start = 1'b1;
        c = 0; done_c = -1; stall = 0; acc = 0;
        prev_clr = 0; en_seen = 0; exp_rise = 0; exp_fall = 0;
        while (done_c < 0 && c < BUDGET) begin
            @(negedge i_clk);
            c++;
            if (c == 1) begin
                check("load_err_clear", o_err, 0);
                check("load_busy", o_busy, 1);
            end
            if (exp_rise) check("valid_rise", o_win_valid, 1);
            if (exp_fall) begin
                check("valid_fall", o_win_valid, 0);
                check("clr_after_accept", o_rrc_clear, 1);
            end
            if (o_rrc_en) en_seen = 1;
            if (o_rrc_clear) begin
                check("clr_single", prev_clr, 0);
                check("en_low_in_adv", o_rrc_en, 0);
            end
            prev_clr = o_rrc_clear;
            if (o_done) begin
                done_c = c;
                check("final_count", o_win_count, nwin);
                check("final_err", o_err, err);
                if (!err) begin
                    check("final_isize", o_i_size, isz);
                    check("final_xy", {o_o_y, o_o_x}, {8'(n - 1), 8'(n - 1)});
                end
            end
            // Drive the inputs for the coming edge.
            i_start = (mode == 1 && c >= 2 && !o_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_rrc_done = (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b1;
            i_pe_ready = (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (mode == 2 && o_win_valid && o_o_x == 1 && o_o_y == 0 && stall < 4) begin
                i_pe_ready = 1'b0;
                stall++;
                check("stall_valid", o_win_valid, 1);
                check("stall_en", o_rrc_en, 1);
                check("stall_clr", o_rrc_clear, 0);
                check("stall_x", o_o_x, 1);
            end
            exp_rise = o_rrc_en && !o_win_valid && i_rrc_done;
            exp_fall = o_win_valid && i_pe_ready;
            if (exp_fall) begin
                if (exp_q.size() == 0) begin
                    check("extra_window", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("window_xy", {o_o_y, o_o_x}, e);
                end
                acc++;
            end
            if (c >= 2) begin
                i_i_size = 8'($urandom_range(0, 255));
                i_k_size = 8'($urandom_range(0, 255));
                i_stride = 8'($urandom_range(0, 255));
            end
        end
        i_start = 1'b0;
        if (done_c < 0) begin
            check("timeout", 0, 1);
        end else if (mode != 1) begin
            check("done_latency", done_c, 3 * nwin + 2 + ((mode == 2) ? 4 : 0));
        end
        check("accept_count", acc, nwin);
        check("en_seen", en_seen, (nwin > 0) ? 1 : 0);
        @(negedge i_clk);
        check("busy_after_done", o_busy, 0);
        check("done_one_cycle", o_done, 0);
    endtask

    task automatic wait_for_valid(input string tag);
        int c = 0;
        while (!o_win_valid && c < 50) begin
            @(negedge i_clk);
            c++;
        end
        check({tag, "_reach_hold"}, o_win_valid, 1);
    endtask

    initial begin
        int isz, k, s;
        repeat (3) @(negedge i_clk);
        check_idle("reset");
        i_nrst = 1'b1;
        @(negedge i_clk);
        check_idle("post_reset");

        run_layer(5, 3, 1, 0);
        run_layer(7, 3, 2, 0);
        run_layer(6, 3, 2, 0);
        run_layer(5, 3, 1, 2);
        run_layer(5, 0, 1, 0);
        run_layer(5, 3, 0, 0);
        run_layer(5, 6, 1, 0);
        run_layer(5, 3, 1, 1);
        run_layer(4, 4, 3, 0);

        // Synchronous clear while a window is waiting; stray start while busy.
        @(negedge i_clk);
        i_i_size = 8'd5; i_k_size = 8'd3; i_stride = 8'd1;
        i_rrc_done = 1'b1; i_pe_ready = 1'b0; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_for_valid("clr");
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("start_ignored_valid", o_win_valid, 1);
        check("start_ignored_count", o_win_count, 0);
        i_reg_clear = 1'b1;
        @(negedge i_clk);
        i_reg_clear = 1'b0;
        check_idle("reg_clear");
        @(negedge i_clk);
        check("clear_stays_idle", o_busy, 0);

        // Asynchronous reset while waiting in RUN.
        i_rrc_done = 1'b0; i_pe_ready = 1'b1; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        check("run_en", o_rrc_en, 1);
        #2 i_nrst = 1'b0;
        #1 check_idle("async_reset");
        @(negedge i_clk);
        i_nrst = 1'b1;
        repeat (2) @(negedge i_clk);
        check("reset_needs_start", o_busy, 0);

        for (int t = 0; t < 10; t++) begin
            isz = $urandom_range(1, 12);
            k = $urandom_range(0, isz + 1);
            s = $urandom_range(0, 4);
            run_layer(isz, k, s, $urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
